// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl
//   Drives one scan chain through a full test sequence: serially loads a
//   pattern (MSB first), pulses one capture cycle, serially unloads the chain,
//   then reports the captured contents and an optional compare result.
//
//   Parameter
//     CHAIN_LEN  number of scan flops in the chain (2..64)
//   Ports
//     CP        clock, rising edge
//     CD        asynchronous active-low reset
//     START     begin a sequence (accepted only in IDLE)
//     ABORT     synchronous abort back to IDLE, no DONE
//     PAT_IN    pattern to load, bit j -> chain position j
//     EXP_IN    expected post-capture contents
//     SO        scan-out from chain position CHAIN_LEN-1
//     TE        registered test enable to the chain
//     TI        registered scan-in to chain position 0
//     BUSY      high outside IDLE
//     DONE      one-cycle completion pulse
//     UNLOAD    captured chain contents, bit j = position j
//     FAIL      UNLOAD != expected, updated together with UNLOAD
//
//   Build option
//     SCAN_CHAIN_CTRL_COMPARE_EN  when defined, EXP_IN is latched and compared;
//                                 otherwise FAIL is tied low.

module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 16
) (
    input  logic                 CP,
    input  logic                 CD,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [CHAIN_LEN-1:0] PAT_IN,
    input  logic [CHAIN_LEN-1:0] EXP_IN,
    input  logic                 SO,
    output logic                 TE,
    output logic                 TI,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CHAIN_LEN-1:0] UNLOAD,
    output logic                 FAIL
);

    localparam int            CW   = $clog2(CHAIN_LEN);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        CAPTURE,
        SHIFT_OUT,
        FINISH
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 te_d, ti_d;
    logic                 load, shift_in, shift_out, commit;
    // pat_q holds the bits still to be sent, pre-shifted so that its MSB is
    // always the bit for the next shift cycle.
    logic [CHAIN_LEN-1:0] pat_q;
    // Unload shadow: UNLOAD is only written once the whole chain is in, so an
    // abort during SHIFT_OUT leaves the previous result intact.
    logic [CHAIN_LEN-2:0] cap_q;
    logic [CHAIN_LEN-1:0] cap_full;

    assign cap_full = {cap_q, SO};
    assign BUSY     = (state_q != IDLE);
    assign DONE     = (state_q == FINISH);

    // TE/TI are computed for the next state and registered, so they change
    // only on CP edges.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        te_d      = 1'b0;
        ti_d      = 1'b0;
        load      = 1'b0;
        shift_in  = 1'b0;
        shift_out = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (START && !ABORT) begin
                    state_d = SHIFT_IN;
                    cnt_d   = '0;
                    te_d    = 1'b1;
                    ti_d    = PAT_IN[CHAIN_LEN-1];
                    load    = 1'b1;
                end
            end
            SHIFT_IN: begin
                shift_in = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    te_d  = 1'b1;
                    ti_d  = pat_q[CHAIN_LEN-1];
                end
            end
            CAPTURE: begin
                state_d = SHIFT_OUT;
                cnt_d   = '0;
                te_d    = 1'b1;
            end
            SHIFT_OUT: begin
                shift_out = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = FINISH;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    te_d  = 1'b1;
                end
            end
            FINISH: begin
                // START here is deliberately not looked at: a new run
                // needs a cycle in IDLE first.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (ABORT && state_q != IDLE) begin
            state_d   = IDLE;
            cnt_d     = '0;
            te_d      = 1'b0;
            ti_d      = 1'b0;
            shift_in  = 1'b0;
            shift_out = 1'b0;
            commit    = 1'b0;
        end
    end

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            TE      <= 1'b0;
            TI      <= 1'b0;
            pat_q   <= '0;
            cap_q   <= '0;
            UNLOAD  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            TE      <= te_d;
            TI      <= ti_d;
            if (load)
                pat_q <= PAT_IN << 1;
            else if (shift_in)
                pat_q <= pat_q << 1;
            // First SO sample lands in the MSB after CHAIN_LEN shifts.
            if (shift_out)
                cap_q <= cap_full[CHAIN_LEN-2:0];
            if (commit)
                UNLOAD <= cap_full;
        end
    end

`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    logic [CHAIN_LEN-1:0] exp_q;

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            exp_q <= '0;
            FAIL  <= 1'b0;
        end else begin
            if (load)
                exp_q <= EXP_IN;
            if (commit)
                FAIL <= (cap_full != exp_q);
        end
    end
`else
    logic unused_exp;

    assign unused_exp = ^EXP_IN;
    assign FAIL       = 1'b0;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: a 4-bit and a 16-bit instance, each driving a
// behavioural scan chain. Expected UNLOAD/FAIL/DONE-cycle are queued when a
// sequence is started and checked when DONE appears.
module tb_scan_chain_ctrl;

    localparam int NA = 4;
    localparam int NB = 16;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    typedef struct {
        logic [63:0] unload;
        logic        fail;
        int          done_cyc;
    } exp_t;

    logic CP = 1'b0;
    logic CD = 1'b0;

    logic          start_a = 0, abort_a = 0, so_a, te_a, ti_a, busy_a, done_a, fail_a;
    logic [NA-1:0] pat_a = '0, exp_a = '0, unload_a;
    logic          start_b = 0, abort_b = 0, so_b, te_b, ti_b, busy_b, done_b, fail_b;
    logic [NB-1:0] pat_b = '0, exp_b = '0, unload_b;

    logic [NA-1:0] ch_a = '0;
    logic [NB-1:0] ch_b = '0;
    logic          hold_a = 1'b1;
    logic [NA-1:0] tie_a = '0;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    always #5 CP = ~CP;
    always @(posedge CP) cyc <= cyc + 1;

    scan_chain_ctrl #(.CHAIN_LEN(NA)) u_a (
        .CP(CP), .CD(CD), .START(start_a), .ABORT(abort_a), .PAT_IN(pat_a),
        .EXP_IN(exp_a), .SO(so_a), .TE(te_a), .TI(ti_a), .BUSY(busy_a),
        .DONE(done_a), .UNLOAD(unload_a), .FAIL(fail_a)
    );

    scan_chain_ctrl #(.CHAIN_LEN(NB)) u_b (
        .CP(CP), .CD(CD), .START(start_b), .ABORT(abort_b), .PAT_IN(pat_b),
        .EXP_IN(exp_b), .SO(so_b), .TE(te_b), .TI(ti_b), .BUSY(busy_b),
        .DONE(done_b), .UNLOAD(unload_b), .FAIL(fail_b)
    );

    // Chain models: shift toward position N-1 when TE, otherwise capture D
    // (hold, or a tied constant for chain A).
    always @(posedge CP) begin
        if (te_a)
            ch_a <= {ch_a[NA-2:0], ti_a};
        else if (!hold_a)
            ch_a <= tie_a;
        if (te_b)
            ch_b <= {ch_b[NB-2:0], ti_b};
    end
    assign so_a = ch_a[NA-1];
    assign so_b = ch_b[NB-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        else
            n_pass++;
    endtask

    function automatic logic exp_fail(input logic [63:0] u, input logic [63:0] e);
        return CMP & (u != e);
    endfunction

    task automatic tick();
        @(negedge CP);
    endtask

    // Called at a negedge; START is sampled at the next posedge (edge 0) and
    // DONE is due 2N+2 cycles after it. Returns at the negedge of cycle 1.
    task automatic start_a_seq(input logic [NA-1:0] p, input logic [NA-1:0] e,
                               input logic [NA-1:0] u, input bit push);
        exp_t x;
        pat_a   = p;
        exp_a   = e;
        start_a = 1'b1;
        if (push) begin
            x.unload   = 64'(u);
            x.fail     = exp_fail(64'(u), 64'(e));
            x.done_cyc = cyc + 2 * NA + 2;
            qa.push_back(x);
        end
        tick();
        start_a = 1'b0;
        pat_a   = NA'($urandom);
        exp_a   = NA'($urandom);
    endtask

    task automatic start_b_seq(input logic [NB-1:0] p, input logic [NB-1:0] e,
                               input logic [NB-1:0] u);
        exp_t x;
        pat_b      = p;
        exp_b      = e;
        start_b    = 1'b1;
        x.unload   = 64'(u);
        x.fail     = exp_fail(64'(u), 64'(e));
        x.done_cyc = cyc + 2 * NB + 2;
        qb.push_back(x);
        tick();
        start_b = 1'b0;
        pat_b   = NB'($urandom);
        exp_b   = NB'($urandom);
    endtask

    // Scoreboard side: every DONE must have a queued expectation.
    always @(negedge CP) begin
        if (done_a) begin
            chk("a_done_expected", 64'(qa.size() != 0), 64'd1);
            if (qa.size() != 0) begin
                ea = qa.pop_front();
                chk("a_done_cycle", 64'(cyc), 64'(ea.done_cyc));
                chk("a_unload", 64'(unload_a), ea.unload);
                chk("a_fail", 64'(fail_a), 64'(ea.fail));
            end
        end
        if (done_b) begin
            chk("b_done_expected", 64'(qb.size() != 0), 64'd1);
            if (qb.size() != 0) begin
                eb = qb.pop_front();
                chk("b_done_cycle", 64'(cyc), 64'(eb.done_cyc));
                chk("b_unload", 64'(unload_b), eb.unload);
                chk("b_fail", 64'(fail_b), 64'(eb.fail));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NA-1:0] p;

        // Reset state
        repeat (3) tick();
        chk("rst_te", 64'(te_a), 64'd0);
        chk("rst_ti", 64'(ti_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_fail", 64'(fail_a), 64'd0);
        chk("rst_unload", 64'(unload_a), 64'd0);
        chk("rst_b_busy", 64'(busy_b), 64'd0);

        // Basic load/unload with hold chain; START on first edge after release
        CD = 1'b1;
        p  = 4'b1011;
        start_a_seq(p, 4'b1011, 4'b1011, 1'b1);
        for (int m = 1; m <= 2 * NA + 2; m++) begin
            chk("seq_te", 64'(te_a), 64'((m <= NA) || (m >= NA + 2 && m <= 2 * NA + 1)));
            chk("seq_ti", 64'(ti_a), 64'((m <= NA) ? p[NA-m] : 1'b0));
            chk("seq_busy", 64'(busy_a), 64'd1);
            tick();
        end
        chk("seq_idle_after", 64'(busy_a), 64'd0);

        // START while busy and during FINISH is ignored
        start_a_seq(4'b0101, 4'b0101, 4'b0101, 1'b1);
        repeat (6) tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (2) tick();
        chk("busy_done_c10", 64'(done_a), 64'd1);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("busy_low_c11", 64'(busy_a), 64'd0);
        tick();
        chk("busy_low_c12", 64'(busy_a), 64'd0);

        // Capture mismatch against a tied chain
        hold_a = 1'b0;
        tie_a  = 4'b0110;
        start_a_seq(4'b1111, 4'b0111, 4'b0110, 1'b1);
        repeat (11) tick();
        hold_a = 1'b1;

        // ABORT in SHIFT_IN cycle 2: no DONE, results retained
        start_a_seq(4'b1001, 4'b1001, 4'b0000, 1'b0);
        tick();
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("abort_te", 64'(te_a), 64'd0);
        chk("abort_busy", 64'(busy_a), 64'd0);
        chk("abort_unload", 64'(unload_a), 64'h6);
        chk("abort_fail", 64'(fail_a), 64'(exp_fail(64'h6, 64'h7)));
        repeat (12) tick();
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        chk("abort_idle_prio", 64'(busy_a), 64'd0);
        start_a_seq(4'b0011, 4'b0011, 4'b0011, 1'b1);
        repeat (11) tick();

        // Asynchronous reset during CAPTURE
        start_a_seq(4'b1110, 4'b1110, 4'b0000, 1'b0);
        repeat (4) tick();
        chk("pre_rst_busy", 64'(busy_a), 64'd1);
        #1 CD = 1'b0;
        #1;
        chk("arst_te", 64'(te_a), 64'd0);
        chk("arst_ti", 64'(ti_a), 64'd0);
        chk("arst_busy", 64'(busy_a), 64'd0);
        chk("arst_unload", 64'(unload_a), 64'd0);
        chk("arst_fail", 64'(fail_a), 64'd0);
        tick();
        CD = 1'b1;
        start_a_seq(4'b1100, 4'b1101, 4'b1100, 1'b1);
        repeat (11) tick();

        // Default size
        start_b_seq(16'hA5C3, 16'hA5C3, 16'hA5C3);
        repeat (35) tick();
        start_b_seq(16'h3C5A, 16'h3C5B, 16'h3C5A);
        repeat (35) tick();

        // Bounded drain of anything still outstanding
        for (int i = 0; i < 50 && (qa.size() != 0 || qb.size() != 0); i++)
            tick();
        chk("a_queue_empty", 64'(qa.size()), 64'd0);
        chk("b_queue_empty", 64'(qb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
